// File: rtl/jtag_ram_write_seq.sv
// jtag_ram_write_seq
//
// Bridges the virtual-JTAG register block into the system clock domain and
// sequences writes into the 64 kB block RAM.
//
// Write side: the asynchronous wram_enable level is synchronized. Each rising
// edge starts one request. The sequencer waits SETTLE cycles so that the
// JTAG-side buses are stable, and then captures address, data and the
// auto-increment flag. It then issues one single-cycle RAM write.
//
// Read side: the read address is registered toward the RAM. Read data is
// registered back toward JTAG, with a bypass when the cycle writes the
// address being read.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   wram_enable         async level from jtag_top; each rise = one write request
//   waddr_in, wdata_in  async JTAG write address / data
//   raddr_in            async JTAG read address
//   flags_in            async JTAG flags; bit 13 selects auto-increment addressing
//   clr_status          sync pulse; clears overrun and write_count
//   ram_we/waddr/wdata  RAM write port (address/data registered, strobe one cycle)
//   ram_raddr/rdata     RAM read port (address registered, data combinational)
//   rdata_out           registered read data toward jtag_top
//   write_count         number of completed writes (wraps)
//   overrun             sticky: a request arrived while the sequencer was busy
//   debug               {ram_waddr[3:0], ram_wdata[3:0]} of the last write
module jtag_ram_write_seq #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int SYNC_LEN = 3,
  parameter int SETTLE   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wram_enable,
  input  logic [DATA_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] raddr_in,
  input  logic [DATA_W-1:0] flags_in,
  input  logic              clr_status,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic [15:0]       write_count,
  output logic              overrun,
  output logic [7:0]        debug
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_WRITE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SYNC_LEN-1:0] sync_reg;
  logic               sync_prev_reg;
  logic [ADDR_W-1:0]  wptr_reg;
  logic               req;
  logic               capture;
  logic               overrun_set;

  // Only the low ADDR_W address bits and flag bit 13 are meaningful.
  logic unused_bits;
  assign unused_bits = ^{waddr_in[DATA_W-1:ADDR_W], raddr_in[DATA_W-1:ADDR_W],
                         flags_in[DATA_W-1:14], flags_in[12:0]};

  // Synchronizer for the asynchronous level. One extra flop gives edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_LEN-2:0], wram_enable};
      sync_prev_reg <= sync_reg[SYNC_LEN-1];
    end
  end

  assign req = sync_reg[SYNC_LEN-1] & ~sync_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter is loaded with SETTLE-1 and counts down to 0 inclusive.
  // As a result, exactly SETTLE cycles are spent in ST_SETTLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    ram_we     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_SETTLE;
          cnt_next   = CNT_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) state_next = ST_CAPTURE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        ram_we     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A request seen while busy, including during the write cycle, is dropped.
  assign overrun_set = req && (state_reg != ST_IDLE);

  // The capture edge loads the RAM write address and data directly. They are
  // valid during ST_WRITE and hold until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_waddr <= '0;
      ram_wdata <= '0;
      wptr_reg  <= '0;
    end else begin
      if (capture) begin
        ram_waddr <= flags_in[13] ? wptr_reg : waddr_in[ADDR_W-1:0];
        ram_wdata <= wdata_in;
      end
      if (ram_we) wptr_reg <= ram_waddr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    end
  end

  // A clear in the same cycle as a write wins, so that write is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count <= '0;
      overrun     <= 1'b0;
      debug       <= '0;
    end else begin
      if (clr_status)  write_count <= '0;
      else if (ram_we) write_count <= write_count + 16'd1;

      if (clr_status)       overrun <= 1'b0;
      else if (overrun_set) overrun <= 1'b1;

      if (ram_we) debug <= {ram_waddr[3:0], ram_wdata[3:0]};
    end
  end

  // Read path. The RAM has not stored a same-cycle write yet, so that write
  // is forwarded instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_raddr <= '0;
      rdata_out <= '0;
    end else begin
      ram_raddr <= raddr_in[ADDR_W-1:0];
      rdata_out <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : ram_rdata;
    end
  end

endmodule

// File: tb/tb_jtag_ram_write_seq.sv
// Directed testbench for jtag_ram_write_seq. It uses the default parameters:
// SYNC_LEN=3 and SETTLE=2, so the write strobe appears 7 edges after the request.
module tb_jtag_ram_write_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        wram_enable;
  logic [31:0] waddr_in, wdata_in, raddr_in, flags_in;
  logic        clr_status;
  logic        ram_we;
  logic [13:0] ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata, rdata_out;
  logic [15:0] write_count;
  logic        overrun;
  logic [7:0]  debug;

  int n_checks = 0;
  int n_fail   = 0;

  int          we_at, we_n;
  logic [13:0] we_addr;
  logic [31:0] we_data, rd_after;

  always #5 clk = ~clk;

  jtag_ram_write_seq dut (
    .clk(clk), .reset(reset), .wram_enable(wram_enable),
    .waddr_in(waddr_in), .wdata_in(wdata_in), .raddr_in(raddr_in),
    .flags_in(flags_in), .clr_status(clr_status),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .rdata_out(rdata_out),
    .write_count(write_count), .overrun(overrun), .debug(debug)
  );

  // Simple RAM stand-in: address 7 holds 0x11, others return a tagged address.
  always_comb begin
    ram_rdata = 32'hA500_0000 | {18'd0, ram_raddr};
    if (ram_raddr == 14'd7) ram_rdata = 32'h0000_0011;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request. The caller must be at a negedge. Buses are held for the
  // whole window, and enable is high for 4 cycles and low for 8.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic inc, input logic clr_on_we);
    waddr_in    = a;
    wdata_in    = d;
    flags_in    = inc ? 32'h0000_2000 : 32'h0;
    we_at       = -1;
    we_n        = 0;
    rd_after    = 32'hx;
    wram_enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) wram_enable = 1'b0;
      if (clr_status) clr_status = 1'b0;
      if (we_at > 0 && k == we_at + 1) rd_after = rdata_out;
      if (ram_we) begin
        we_n++;
        if (we_at < 0) begin
          we_at   = k;
          we_addr = ram_waddr;
          we_data = ram_wdata;
          if (clr_on_we) clr_status = 1'b1;
        end
      end
    end
    $display("txn write a=%h d=%h inc=%0d: we_at=%0d n=%0d addr=%0d data=%h cnt=%0d",
             a, d, inc, we_at, we_n, we_addr, we_data, write_count);
  endtask

  task automatic expect_write(input string tag, input logic [13:0] addr, input logic [31:0] data);
    check_eq({tag, "_latency"}, we_at, 7);
    check_eq({tag, "_strobes"}, we_n, 1);
    check_eq({tag, "_addr"}, {18'd0, we_addr}, {18'd0, addr});
    check_eq({tag, "_data"}, we_data, data);
  endtask

  initial begin
    int n;
    reset = 1'b1; wram_enable = 1'b1; clr_status = 1'b0;
    waddr_in = '0; wdata_in = '0; raddr_in = '0; flags_in = '0;

    // Reset with enable held high: all outputs must be zero.
    repeat (3) @(negedge clk);
    check_eq("rst_we", ram_we, 0);
    check_eq("rst_waddr", ram_waddr, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    check_eq("rst_raddr", ram_raddr, 0);
    check_eq("rst_rdata", rdata_out, 0);
    check_eq("rst_count", write_count, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_debug", debug, 0);
    $display("txn reset: outputs checked during reset");
    wram_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (12) begin @(negedge clk); if (ram_we) n++; end
    check_eq("idle_no_we", n, 0);
    $display("txn idle after reset: strobes=%0d", n);

    // Single write.
    do_req(32'h5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expect_write("single", 14'd5, 32'hDEAD_BEEF);
    check_eq("single_debug", debug, 8'h5F);
    check_eq("single_count", write_count, 1);
    check_eq("single_overrun", overrun, 0);
    check_eq("single_hold_addr", ram_waddr, 5);

    // Auto-increment wrap.
    do_req(32'd16382, 32'h1000, 1'b0, 1'b0);
    expect_write("wrap0", 14'd16382, 32'h1000);
    do_req(32'h123, 32'h1001, 1'b1, 1'b0);
    expect_write("wrap1", 14'd16383, 32'h1001);
    do_req(32'h123, 32'h1002, 1'b1, 1'b0);
    expect_write("wrap2", 14'd0, 32'h1002);
    do_req(32'h123, 32'h1003, 1'b1, 1'b0);
    expect_write("wrap3", 14'd1, 32'h1003);
    check_eq("wrap_count", write_count, 5);
    check_eq("wrap_debug", debug, 8'h13);

    // Overrun: a second rise 3 cycles after the first is dropped.
    waddr_in = 32'h20; wdata_in = 32'hCAFE_0001; flags_in = '0;
    wram_enable = 1'b1;
    n = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) wram_enable = 1'b0;
      if (k == 3) wram_enable = 1'b1;
      if (k == 5) wram_enable = 1'b0;
      if (ram_we) n++;
    end
    $display("txn overrun: strobes=%0d overrun=%0d cnt=%0d", n, overrun, write_count);
    check_eq("ovr_strobes", n, 1);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_count", write_count, 6);
    check_eq("ovr_addr", ram_waddr, 14'h20);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check_eq("clr_overrun", overrun, 0);
    check_eq("clr_count", write_count, 0);
    $display("txn clr_status: overrun=%0d cnt=%0d", overrun, write_count);

    // Read latency, then a bypass write that collides with a clear.
    raddr_in = 32'd7;
    @(negedge clk);
    check_eq("rd_lat1", rdata_out, 32'hA500_0000);
    @(negedge clk);
    check_eq("rd_lat2", rdata_out, 32'h11);
    $display("txn read addr 7: rdata=%h", rdata_out);
    do_req(32'd7, 32'h22, 1'b0, 1'b1);
    expect_write("byp", 14'd7, 32'h22);
    check_eq("byp_rdata", rd_after, 32'h22);
    check_eq("byp_after", rdata_out, 32'h11);
    check_eq("byp_clr_count", write_count, 0);
    check_eq("byp_debug", debug, 8'h72);

    do_req(32'd9, 32'h3C, 1'b0, 1'b0);
    expect_write("w9", 14'd9, 32'h3C);
    check_eq("w9_count", write_count, 1);
    check_eq("w9_debug", debug, 8'h9C);

    // Reset pulsed during SETTLE aborts the write.
    waddr_in = 32'h55; wdata_in = 32'h77; flags_in = '0;
    wram_enable = 1'b1;
    @(negedge clk); wram_enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_count", write_count, 0);
    check_eq("mid_debug", debug, 0);
    check_eq("mid_waddr", ram_waddr, 0);
    n = 0;
    repeat (12) begin @(negedge clk); if (ram_we) n++; end
    check_eq("mid_no_we", n, 0);
    check_eq("mid_count2", write_count, 0);
    $display("txn reset mid-sequence: strobes=%0d cnt=%0d", n, write_count);

    // The write pointer restarts from 0 after reset.
    do_req(32'h1234, 32'hABCD_0000, 1'b1, 1'b0);
    expect_write("ptr_rst", 14'd0, 32'hABCD_0000);
    check_eq("ptr_rst_count", write_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
